text_render_ctrl: RTL and testbench
===================================

TEXT_RENDER_CTRL -- requirements
Module: text_render_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per frame.
REQ-003 SHALL have parameter BLINK_FRAMES, default 32, meaning frames per cursor blink half-period.
REQ-004 Ports; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- de_in  in  1  active video from timing generator
- hsync_in  in  1  horizontal sync, passed through
- vsync_in  in  1  vertical sync, passed through; rising edge = frame boundary
- x_in  in  10  pixel x within active area
- y_in  in  9  pixel y within active area
- txt_addr  out  12  text RAM read address
- txt_data  in  8  text RAM data, valid 1 cycle after txt_addr; [7] inverse attribute, [6:0] ASCII code
- font_ascii  out  7  font ROM character code
- font_row  out  4  font ROM glyph row 0-15
- font_col  out  3  font ROM glyph column 0-7
- font_pixel  in  1  font ROM pixel, valid 1 cycle after font address
- cursor_x  in  7  cursor character column
- cursor_y  in  5  cursor character row
- cursor_en  in  1  cursor enable
- fg_in  in  3  foreground RGB, frame-latched
- bg_in  in  3  background RGB, frame-latched
- de_out, hsync_out, vsync_out  out  1 each  syncs delayed to match rgb_out
- rgb_out  out  3  pixel colour

Function
REQ-005 Pipeline SHALL be 5 stages: inputs sampled at edge N produce rgb_out/de_out/hsync_out/vsync_out at edge N+5; no stalls, throughput 1 pixel/cycle.
REQ-006 Edge N+1: when de_in=1, txt_addr SHALL be y_in[8:4]*COLS + x_in[9:3] (max 2399 at defaults); when de_in=0, txt_addr SHALL hold.
REQ-007 Edge N+3: font_ascii SHALL be txt_data[6:0] as sampled at N+2; font_row=y_in[3:0] and font_col=x_in[2:0] SHALL be delayed 3 cycles from N.
REQ-008 Inverse bit txt_data[7], cursor match and glyph row SHALL be carried alongside to the stage where font_pixel arrives (N+4).
REQ-009 Pixel function at N+5: p = font_pixel XOR inverse; if cursor_active then p=1; rgb_out = p ? fg_q : bg_q.
REQ-010 cursor_active SHALL be cursor_en AND blink_phase AND (char col == cursor_x) AND (char row == cursor_y) AND glyph row in {14,15}.
REQ-011 When delayed de=0, rgb_out SHALL be 3'b000 regardless of other inputs.
REQ-012 Pixels with x_in >= COLS*8 or y_in >= ROWS*16 while de_in=1 SHALL output bg_q; txt_addr SHALL hold for them.
REQ-013 Frame boundary = vsync_in 0->1 registered edge; on it fg_q<=fg_in, bg_q<=bg_in, and blink counter advances.
REQ-014 Blink counter (width ceil(log2(BLINK_FRAMES))) SHALL wrap BLINK_FRAMES-1 -> 0 and toggle blink_phase on that wrap.
REQ-015 cursor_x/cursor_y/cursor_en SHALL be sampled live at stage N+1; mid-frame changes take effect on next pixel.
REQ-016 Simultaneous vsync edge and active pixel: pixels already in pipeline SHALL use the old fg_q/bg_q only if they reach stage N+5 before the latch edge.

Reset
REQ-017 On rst=1 at an edge: txt_addr, font_ascii, font_row, font_col, rgb_out, de_out, hsync_out, vsync_out SHALL be 0; all pipeline valid/sync bits 0; blink counter 0; blink_phase 0; fg_q=3'b111; bg_q=3'b000; previous-vsync register 0.
REQ-018 Reset mid-line SHALL flush the pipeline; the first 5 outputs after rst deasserts SHALL have de_out=0, rgb_out=0.

Verification
REQ-019 Latency: de_in pulse at edge 10, x=0,y=0, txt RAM[0]=0x41, font model returns 1 -> de_out=1, rgb_out=3'b111 at edge 15; txt_addr=0 at 11; font_ascii=0x41 at 13.
REQ-020 Addressing: x_in=637, y_in=479 -> txt_addr=2399, font_col=5, font_row=15 after 3 edges.
REQ-021 Inverse: txt RAM[0]=0xC1, font_pixel=1 -> rgb_out=bg_q (3'b000); font_pixel=0 -> fg_q.
REQ-022 Cursor/blink: cursor_en=1, cursor=(2,1), 32 vsync rising edges -> blink_phase=1; pixel x=16..23, y=30 -> rgb_out=fg_q; y=29 -> glyph-driven; after 32 more frames -> glyph-driven.
REQ-023 Config latch: change fg_in to 3'b010 mid-frame -> rgb_out unchanged until first pixel after next vsync rising edge, then 3'b010.
REQ-024 Reset mid-operation: rst=1 for 1 cycle during active line -> all outputs 0 next edge; de_out=0 for 5 edges after release; blink counter restarts at 0.

Source files
------------

// File: rtl/text_render_if.sv
// Signal bundle between the text renderer, its timing source and its text/font memories.
interface text_render_if;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  x_in;
    logic [8:0]  y_in;
    logic [11:0] txt_addr;
    logic [7:0]  txt_data;
    logic [6:0]  font_ascii;
    logic [3:0]  font_row;
    logic [2:0]  font_col;
    logic        font_pixel;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        cursor_en;
    logic [2:0]  fg_in;
    logic [2:0]  bg_in;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic [2:0]  rgb_out;

    modport slave (
        input  de_in, hsync_in, vsync_in, x_in, y_in, txt_data, font_pixel,
               cursor_x, cursor_y, cursor_en, fg_in, bg_in,
        output txt_addr, font_ascii, font_row, font_col,
               de_out, hsync_out, vsync_out, rgb_out
    );

    modport master (
        output de_in, hsync_in, vsync_in, x_in, y_in, txt_data, font_pixel,
               cursor_x, cursor_y, cursor_en, fg_in, bg_in,
        input  txt_addr, font_ascii, font_row, font_col,
               de_out, hsync_out, vsync_out, rgb_out
    );
endinterface

// File: rtl/text_render_ctrl.sv
// Five-stage character-cell text renderer: text RAM lookup, font ROM lookup,
// inverse/cursor overlay and frame-latched colours, one pixel per clock.
module text_render_ctrl #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32
) (
    input logic          clk,
    input logic          rst,
    text_render_if.slave bus
);
    localparam int             BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [10:0]    X_LIM   = 11'(COLS * 8);
    localparam logic [9:0]     Y_LIM   = 10'(ROWS * 16);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    function automatic logic [2:0] pixel_colour(input logic de, input logic in_range,
                                                input logic pix, input logic [2:0] fg,
                                                input logic [2:0] bg);
        if (!de)            return 3'b000;
        else if (!in_range) return bg;
        else                return pix ? fg : bg;
    endfunction

    // Control state (reset)
    logic [5:0]         de_pipe_q, hs_pipe_q, vs_pipe_q;
    logic               vs_prev_q;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [2:0]         fg_q, bg_q;
    logic [11:0]        txt_addr_q;
    logic [6:0]         font_ascii_q;
    logic [3:0]         font_row_q;
    logic [2:0]         font_col_q;
    logic [2:0]         rgb_q;

    // Datapath carries (no reset)
    logic [9:0]  x_p0_q;
    logic [8:0]  y_p0_q;
    logic        inr_p1_q, inr_p2_q, inr_p3_q, inr_p4_q;
    logic        cur_p1_q, cur_p2_q, cur_p3_q, cur_p4_q;
    logic        inv_p3_q, inv_p4_q;
    logic [3:0]  row_p1_q, row_p2_q;
    logic [2:0]  col_p1_q, col_p2_q;

    logic        frame_edge;
    logic        in_range_p0;
    logic        cur_d;
    logic [11:0] addr_d;
    logic        pix_d;

    assign frame_edge  = bus.vsync_in && !vs_prev_q;
    assign in_range_p0 = ({1'b0, x_p0_q} < X_LIM) && ({1'b0, y_p0_q} < Y_LIM);
    assign addr_d      = 12'(32'(y_p0_q[8:4]) * COLS) + 12'(x_p0_q[9:3]);
    // Cursor underline occupies glyph rows 14 and 15 of the matching cell.
    assign cur_d       = bus.cursor_en && blink_q &&
                         (x_p0_q[9:3] == bus.cursor_x) && (y_p0_q[8:4] == bus.cursor_y) &&
                         (y_p0_q[3:1] == 3'b111);
    assign pix_d       = cur_p4_q | (bus.font_pixel ^ inv_p4_q);

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (frame_edge) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_pipe_q    <= '0;
            hs_pipe_q    <= '0;
            vs_pipe_q    <= '0;
            vs_prev_q    <= 1'b0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            fg_q         <= 3'b111;
            bg_q         <= 3'b000;
            txt_addr_q   <= '0;
            font_ascii_q <= '0;
            font_row_q   <= '0;
            font_col_q   <= '0;
            rgb_q        <= '0;
        end else begin
            de_pipe_q   <= {de_pipe_q[4:0], bus.de_in};
            hs_pipe_q   <= {hs_pipe_q[4:0], bus.hsync_in};
            vs_pipe_q   <= {vs_pipe_q[4:0], bus.vsync_in};
            vs_prev_q   <= bus.vsync_in;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            if (frame_edge) begin
                fg_q <= bus.fg_in;
                bg_q <= bus.bg_in;
            end
            // stage 1: text RAM address
            if (de_pipe_q[0] && in_range_p0) txt_addr_q <= addr_d;
            // stage 3: font ROM address
            font_ascii_q <= bus.txt_data[6:0];
            font_row_q   <= row_p2_q;
            font_col_q   <= col_p2_q;
            // stage 5: pixel colour
            rgb_q        <= pixel_colour(de_pipe_q[4], inr_p4_q, pix_d, fg_q, bg_q);
        end
    end

    always_ff @(posedge clk) begin
        x_p0_q   <= bus.x_in;
        y_p0_q   <= bus.y_in;
        inr_p1_q <= in_range_p0;
        cur_p1_q <= cur_d;
        row_p1_q <= y_p0_q[3:0];
        col_p1_q <= x_p0_q[2:0];
        inr_p2_q <= inr_p1_q;
        cur_p2_q <= cur_p1_q;
        row_p2_q <= row_p1_q;
        col_p2_q <= col_p1_q;
        inr_p3_q <= inr_p2_q;
        cur_p3_q <= cur_p2_q;
        inv_p3_q <= bus.txt_data[7];
        inr_p4_q <= inr_p3_q;
        cur_p4_q <= cur_p3_q;
        inv_p4_q <= inv_p3_q;
    end

    assign bus.txt_addr   = txt_addr_q;
    assign bus.font_ascii = font_ascii_q;
    assign bus.font_row   = font_row_q;
    assign bus.font_col   = font_col_q;
    assign bus.de_out     = de_pipe_q[5];
    assign bus.hsync_out  = hs_pipe_q[5];
    assign bus.vsync_out  = vs_pipe_q[5];
    assign bus.rgb_out    = rgb_q;
endmodule

// File: tb/tb_text_render_ctrl.sv
// Bench for text_render_ctrl: text RAM / font ROM models plus a per-pixel
// reference computed from character-cell arithmetic.
module tb_text_render_ctrl;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int BF   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    text_render_if bus ();

    text_render_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram [4096];
    int         font_mode;
    int         total = 0;
    int         bad   = 0;
    logic [2:0] fg_m, bg_m;
    int         frames_m;
    logic       vs_last_m;
    logic [5:0] exp_q [$];

    function automatic logic glyph(input logic [6:0] a, input logic [3:0] r, input logic [2:0] c);
        int h;
        if (font_mode == 1) return 1'b1;
        if (font_mode == 2) return 1'b0;
        h = int'(a) * 13 + int'(r) * 7 + int'(c) * 5;
        return h[2];
    endfunction

    // Memory models: both return data one clock after the address
    always @(posedge clk) begin
        bus.txt_data   <= ram[bus.txt_addr];
        bus.font_pixel <= glyph(bus.font_ascii, bus.font_row, bus.font_col);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_out(input logic de, input logic hs, input logic vs,
                                             input int x, input int y);
        logic [2:0] c;
        logic [7:0] ch;
        logic       p;
        logic       phase;
        c     = 3'b000;
        phase = ((frames_m / BF) % 2) == 1;
        if (de) begin
            if (x >= COLS * 8 || y >= ROWS * 16) begin
                c = bg_m;
            end else begin
                ch = ram[(y / 16) * COLS + x / 8];
                p  = glyph(ch[6:0], 4'(y % 16), 3'(x % 8)) ^ ch[7];
                if (bus.cursor_en && phase && (x / 8 == int'(bus.cursor_x)) &&
                    (y / 16 == int'(bus.cursor_y)) && (y % 16 >= 14)) p = 1'b1;
                c = p ? fg_m : bg_m;
            end
        end
        return {de, hs, vs, c};
    endfunction

    task automatic step(input logic de, input logic hs, input logic vs, input int x, input int y);
        bus.de_in    = de;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.x_in     = 10'(x);
        bus.y_in     = 9'(y);
        if (vs && !vs_last_m) begin
            frames_m++;
            fg_m = bus.fg_in;
            bg_m = bus.bg_in;
        end
        vs_last_m = vs;
        exp_q.push_back(model_out(de, hs, vs, x, y));
        @(posedge clk);
        #1;
        chk("pix", 32'({bus.de_out, bus.hsync_out, bus.vsync_out, bus.rgb_out}), 32'(exp_q.pop_front()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic frame();
        idle(6);
        step(1'b0, 1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 1'b1, 0, 0);
        idle(6);
    endtask

    task automatic line(input int y);
        for (int x = 8; x < 32; x++) step(1'b1, 1'b0, 1'b0, x, y);
        idle(6);
    endtask

    task automatic do_reset(input int cycles, input logic de, input int x, input int y);
        rst          = 1'b1;
        bus.de_in    = de;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b0;
        bus.x_in     = 10'(x);
        bus.y_in     = 9'(y);
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_out", {bus.txt_addr, bus.font_ascii, bus.font_row, bus.font_col, bus.rgb_out,
                        bus.de_out, bus.hsync_out, bus.vsync_out}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) exp_q.push_back(6'd0);
        fg_m      = 3'b111;
        bg_m      = 3'b000;
        frames_m  = 0;
        vs_last_m = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[0]        = 8'h41;
        font_mode     = 1;
        bus.cursor_en = 1'b0;
        bus.cursor_x  = 7'd0;
        bus.cursor_y  = 5'd0;
        bus.fg_in     = 3'b111;
        bus.bg_in     = 3'b000;
        do_reset(2, 1'b0, 0, 0);
        idle(4);

        // Addressing at the far corner, then hold on blanking and out-of-range pixels
        step(1'b1, 1'b0, 1'b0, 637, 479);
        idle(1);
        chk("addr_max", 32'(bus.txt_addr), 32'd2399);
        step(1'b1, 1'b0, 1'b0, 700, 10);
        chk("addr_hold_de0", 32'(bus.txt_addr), 32'd2399);
        step(1'b1, 1'b0, 1'b0, 100, 500);
        chk("font_col", 32'(bus.font_col), 32'd5);
        chk("font_row", 32'(bus.font_row), 32'd15);
        idle(1);
        chk("addr_hold_oor", 32'(bus.txt_addr), 32'd2399);
        idle(6);

        // Latency of a single pixel at the origin
        step(1'b1, 1'b0, 1'b0, 0, 0);
        idle(1);
        chk("addr0", 32'(bus.txt_addr), 32'd0);
        idle(2);
        chk("ascii", 32'(bus.font_ascii), 32'h41);
        idle(6);

        // Inverse attribute
        ram[0] = 8'hC1;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        idle(6);
        font_mode = 2;
        step(1'b1, 1'b0, 1'b0, 0, 0);
        idle(6);

        // Randomised traffic with random colours and an armed cursor
        font_mode     = 0;
        bus.cursor_en = 1'b1;
        bus.cursor_x  = 7'($urandom_range(0, 79));
        bus.cursor_y  = 5'($urandom_range(0, 29));
        bus.fg_in     = 3'($urandom);
        bus.bg_in     = 3'($urandom);
        frame();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'b0,
                 $urandom_range(0, 700), $urandom_range(0, 511));
        idle(6);

        // Cursor blink over frames
        do_reset(1, 1'b0, 0, 0);
        font_mode     = 2;
        bus.cursor_en = 1'b1;
        bus.cursor_x  = 7'd2;
        bus.cursor_y  = 5'd1;
        bus.fg_in     = 3'b101;
        bus.bg_in     = 3'b010;
        for (int c = 1; c < 4; c++) ram[COLS + c] = 8'h20;
        idle(6);
        line(30);
        for (int f = 0; f < BF; f++) frame();
        line(30);
        line(29);

        // Reset in the middle of an active line restarts the blink count
        for (int x = 8; x < 20; x++) step(1'b1, 1'b0, 1'b0, x, 30);
        do_reset(1, 1'b1, 20, 30);
        idle(6);
        for (int f = 0; f < BF - 1; f++) frame();
        line(30);
        frame();
        line(30);
        for (int f = 0; f < BF; f++) frame();
        line(30);

        // Colour change mid-frame only shows after the next frame boundary
        font_mode = 1;
        for (int c = 0; c < 8; c++) ram[c] = 8'h20;
        for (int x = 0; x < 32; x++) step(1'b1, 1'b0, 1'b0, x, 0);
        bus.fg_in = 3'b010;
        for (int x = 32; x < 64; x++) step(1'b1, 1'b0, 1'b0, x, 0);
        frame();
        for (int x = 0; x < 64; x++) step(1'b1, 1'b0, 1'b0, x, 0);
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
